// File: rtl/piano_key_sched.sv
// rtl/piano_key_sched.sv - debounced four-key note scheduler with press-order stack and release tail
module piano_key_sched #(
  parameter int DEBOUNCE    = 665000,
  parameter int DBW         = 20,
  parameter int TAIL_CYCLES = 6650000,
  parameter int TW          = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1,
  input  logic       key2,
  input  logic       key3,
  input  logic       key4,
  output logic [3:0] held,
  output logic       note_valid,
  output logic [1:0] note_idx,
  output logic       note_start
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;

  logic [3:0]     keys;
  logic [3:0]     s1, s2, held_prev;
  logic [DBW-1:0] cnt [4];
  logic [3:0]     rise, fall;
  // Stack entry j lives in bits [2j+1:2j]; entry depth-1 is the top.
  logic [7:0]     stk, stk_nx;
  logic [2:0]     depth, depth_nx;
  logic [1:0]     top_nx;
  logic [1:0]     state;
  logic [TW-1:0]  tail_cnt;

  assign keys = {key4, key3, key2, key1};
  assign rise = held & ~held_prev;
  assign fall = ~held & held_prev;

  // Drop key k from the stack, compacting the entries above it downward.
  function automatic logic [10:0] st_remove(input logic [10:0] st, input logic [1:0] k);
    logic [7:0] e;
    logic [7:0] n;
    logic [2:0] d;
    logic [2:0] o;
    e = st[7:0];
    d = st[10:8];
    n = 8'd0;
    o = 3'd0;
    for (int j = 0; j < 4; j++) begin
      if ((3'(j) < d) && (e[2*j +: 2] != k)) begin
        n[{o[1:0], 1'b0} +: 2] = e[2*j +: 2];
        o = o + 3'd1;
      end
    end
    return {o, n};
  endfunction

  // Push key k on top; the stack can never hold more than the four keys.
  function automatic logic [10:0] st_push(input logic [10:0] st, input logic [1:0] k);
    logic [7:0] e;
    logic [2:0] d;
    e = st[7:0];
    d = st[10:8];
    if (d < 3'd4) begin
      e[{d[1:0], 1'b0} +: 2] = k;
      d = d + 3'd1;
    end
    return {d, e};
  endfunction

  // Two-flop synchronizer for the asynchronous key levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 4'd0;
      s2 <= 4'd0;
    end else begin
      s1 <= keys;
      s2 <= s1;
    end
  end

  // Per-key debounce: accept a new level only after it persists DEBOUNCE cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= 4'd0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s2[i] != held[i]) begin
          if (cnt[i] == DBW'(DEBOUNCE - 1)) begin
            held[i] <= s2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Previous-cycle copy of held for edge detection.
  always_ff @(posedge clk) begin
    if (rst) held_prev <= 4'd0;
    else     held_prev <= held;
  end

  // Next stack: releases first, then presses in ascending key order so the highest key lands on top.
  always_comb begin
    logic [10:0] st;
    st = {depth, stk};
    for (int k = 0; k < 4; k++) begin
      if (fall[k]) st = st_remove(st, 2'(k));
    end
    for (int k = 0; k < 4; k++) begin
      if (rise[k]) st = st_push(st_remove(st, 2'(k)), 2'(k));
    end
    stk_nx   = st[7:0];
    depth_nx = st[10:8];
    case (depth_nx)
      3'd1:    top_nx = stk_nx[1:0];
      3'd2:    top_nx = stk_nx[3:2];
      3'd3:    top_nx = stk_nx[5:4];
      3'd4:    top_nx = stk_nx[7:6];
      default: top_nx = 2'd0;
    endcase
  end

  // Register the press-order stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      stk   <= 8'd0;
      depth <= 3'd0;
    end else begin
      stk   <= stk_nx;
      depth <= depth_nx;
    end
  end

  // Gate FSM; it looks at the next stack so outputs follow the stack on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tail_cnt   <= '0;
      note_valid <= 1'b0;
      note_idx   <= 2'd0;
      note_start <= 1'b0;
    end else begin
      note_start <= 1'b0;
      case (state)
        ST_PLAY: begin
          if (depth_nx != 3'd0) begin
            note_idx   <= top_nx;
            note_start <= (top_nx != note_idx);
          end else if (TAIL_CYCLES == 0) begin
            state      <= ST_IDLE;
            note_valid <= 1'b0;
          end else begin
            state    <= ST_TAIL;
            tail_cnt <= '0;
          end
        end
        ST_TAIL: begin
          if (depth_nx != 3'd0) begin
            state      <= ST_PLAY;
            note_idx   <= top_nx;
            note_start <= 1'b1;
          end else if (tail_cnt == TW'(TAIL_CYCLES - 1)) begin
            state      <= ST_IDLE;
            note_valid <= 1'b0;
          end else begin
            tail_cnt <= tail_cnt + 1'b1;
          end
        end
        default: begin
          if (depth_nx != 3'd0) begin
            state      <= ST_PLAY;
            note_idx   <= top_nx;
            note_valid <= 1'b1;
            note_start <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
